alu_share_arbiter: RTL and testbench

- Shares the single registered ALU (ports clk, n_rst, rd1, rd2, ALU_Operation, out) between two requesters: port 0 is the pipeline execute stage and port 1 is the multicycle/aux unit.
- Each requester uses a valid/ready request and receives a one-cycle response pulse.
- Round-robin grant, one operation in flight at a time.
- Sits between the requesters and the ALU instance. It owns the ALU operand, opcode and sampling timing.

---
 rtl/alu_share_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two valid/ready requesters.
// Optional grant/conflict statistics are enabled by defining ALU_ARB_STATS_EN.
`timescale 1ns/1ps
module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_rd1,
  input  logic [DATA_W-1:0] req0_rd2,
  input  logic [3:0]        req0_op,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_result,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_rd1,
  input  logic [DATA_W-1:0] req1_rd2,
  input  logic [3:0]        req1_op,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_result,
  output logic [DATA_W-1:0] alu_rd1,
  output logic [DATA_W-1:0] alu_rd2,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
  output logic [15:0]       conflict_cnt,
`endif
  output logic              busy
);

  localparam int CNT_W = $clog2(ALU_LAT + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT);

  generate
    if (ALU_LAT < 1) begin : g_bad_lat
      $error("alu_share_arbiter: ALU_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             accept;
  logic             conflict;
  logic [CNT_W-1:0] cnt;

  // Combinational grant: a lone requester always wins, a conflict goes to the port not served last.
  always_comb begin
    conflict = req0_valid && req1_valid;
    grant    = req1_valid;
    if (conflict) grant = ~last_grant;
  end

  assign req0_ready = n_rst && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = n_rst && (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);
  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) && owner;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (cnt == CNT_LAST) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        cnt        <= '0;
      end else if (state == EXEC) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Issue stage: operands stay frozen at the ALU until the next accept.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      alu_rd1 <= '0;
      alu_rd2 <= '0;
      alu_op  <= 4'b0000;
    end else if (accept) begin
      alu_rd1 <= grant ? req1_rd1 : req0_rd1;
      alu_rd2 <= grant ? req1_rd2 : req0_rd2;
      alu_op  <= grant ? req1_op  : req0_op;
    end
  end

  // Response stage: sample the ALU one edge after its result settles.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rsp0_result <= '0;
      rsp1_result <= '0;
    end else if ((state == EXEC) && (cnt == CNT_LAST)) begin
      if (owner) rsp1_result <= alu_out;
      else       rsp0_result <= alu_out;
    end
  end

`ifdef ALU_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      grant_cnt0   <= '0;
      grant_cnt1   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= sat_inc(grant_cnt0);
      if (req1_ready) grant_cnt1 <= sat_inc(grant_cnt1);
      if ((state == IDLE) && conflict) conflict_cnt <= sat_inc(conflict_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a cycle-level reference model predicts grants and
// responses, a monitor pops expected responses; a second instance covers ALU_LAT=3.
`timescale 1ns/1ps
module tb_alu_share_arbiter;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req0_valid = 0, req1_valid = 0;
  logic [31:0] req0_rd1 = 0, req0_rd2 = 0, req1_rd1 = 0, req1_rd2 = 0;
  logic [3:0]  req0_op = 0, req1_op = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [31:0] rsp0_result, rsp1_result, alu_rd1, alu_rd2, alu_out;
  logic [3:0]  alu_op;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] gc0, gc1, cc, gc0_3, gc1_3, cc_3;
`endif

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 3))
      0: return 4'b0000;
      1: return 4'b0001;
      2: return 4'b0010;
      default: return 4'b0110;
    endcase
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural registered ALU with a one-edge latency.
  logic [31:0] p1;
  always @(posedge clk) p1 <= alu_ref(alu_rd1, alu_rd2, alu_op);
  assign alu_out = p1;

  alu_share_arbiter #(.DATA_W(32), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(req0_valid), .req0_rd1(req0_rd1), .req0_rd2(req0_rd2), .req0_op(req0_op),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result),
    .req1_valid(req1_valid), .req1_rd1(req1_rd1), .req1_rd2(req1_rd2), .req1_op(req1_op),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result),
    .alu_rd1(alu_rd1), .alu_rd2(alu_rd2), .alu_op(alu_op), .alu_out(alu_out),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(gc0), .grant_cnt1(gc1), .conflict_cnt(cc),
`endif
    .busy(busy)
  );

  // Second instance with a three-edge ALU; only port 0 is exercised.
  logic        r3_valid = 0;
  logic [31:0] r3_rd1 = 0, r3_rd2 = 0;
  logic [3:0]  r3_op = 0;
  logic        r3_ready, r3_rsp_valid, r3_ready1, r3_rsp1_valid, r3_busy;
  logic [31:0] r3_rsp_result, r3_rsp1_result, a3_rd1, a3_rd2;
  logic [3:0]  a3_op;
  logic [31:0] p3 [LAT3];
  always @(posedge clk) begin
    p3[0] <= alu_ref(a3_rd1, a3_rd2, a3_op);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  alu_share_arbiter #(.DATA_W(32), .ALU_LAT(LAT3)) u_dut3 (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(r3_valid), .req0_rd1(r3_rd1), .req0_rd2(r3_rd2), .req0_op(r3_op),
    .req0_ready(r3_ready), .rsp0_valid(r3_rsp_valid), .rsp0_result(r3_rsp_result),
    .req1_valid(1'b0), .req1_rd1(32'h0), .req1_rd2(32'h0), .req1_op(4'h0),
    .req1_ready(r3_ready1), .rsp1_valid(r3_rsp1_valid), .rsp1_result(r3_rsp1_result),
    .alu_rd1(a3_rd1), .alu_rd2(a3_rd2), .alu_op(a3_op), .alu_out(p3[LAT3-1]),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(gc0_3), .grant_cnt1(gc1_3), .conflict_cnt(cc_3),
`endif
    .busy(r3_busy)
  );

  typedef struct {
    int          port;
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: arbiter is free LAT+3 cycles after an accept; conflicts alternate.
  int          m_last = 1, m_free = 0, m_acc = -100;
  int          m_g0 = 0, m_g1 = 0, m_conf = 0;
  logic [31:0] m_a = 0, m_b = 0;
  logic [3:0]  m_op = 0;
  always @(negedge clk) begin
    int   g;
    logic g_valid;
    exp_t e;
    if (!n_rst) begin
      m_last = 1; m_free = 0; m_acc = -100;
      m_g0 = 0; m_g1 = 0; m_conf = 0;
      exp_q.delete();
      chk1("reset_ready0", req0_ready, 1'b0);
      chk1("reset_ready1", req1_ready, 1'b0);
      chk1("reset_busy", busy, 1'b0);
    end else begin
      g = 0;
      g_valid = 1'b0;
      if (cyc >= m_free) begin
        if (req0_valid && req1_valid) begin
          g_valid = 1'b1; g = 1 - m_last; m_conf++;
        end else if (req0_valid) begin
          g_valid = 1'b1; g = 0;
        end else if (req1_valid) begin
          g_valid = 1'b1; g = 1;
        end
      end
      chk1("ready0", req0_ready, g_valid && g == 0);
      chk1("ready1", req1_ready, g_valid && g == 1);
      chk1("busy", busy, cyc > m_acc && cyc < m_free);
      if (cyc > m_acc && cyc <= m_acc + LAT + 1) begin
        chk32("alu_rd1_stable", alu_rd1, m_a);
        chk32("alu_rd2_stable", alu_rd2, m_b);
        chk32("alu_op_stable", {28'h0, alu_op}, {28'h0, m_op});
      end
      if (g_valid) begin
        m_a  = (g == 0) ? req0_rd1 : req1_rd1;
        m_b  = (g == 0) ? req0_rd2 : req1_rd2;
        m_op = (g == 0) ? req0_op : req1_op;
        e.port = g;
        e.res  = alu_ref(m_a, m_b, m_op);
        e.cyc  = cyc + LAT + 2;
        exp_q.push_back(e);
        m_last = g; m_acc = cyc; m_free = cyc + LAT + 3;
        if (g == 0) m_g0++; else m_g1++;
      end
    end
  end

  // Monitor: every response pulse must match the oldest expected response.
  logic [31:0] hold0 = 0, hold1 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!n_rst) begin
      hold0 = 0; hold1 = 0;
      chk1("reset_rsp0_valid", rsp0_valid, 1'b0);
      chk1("reset_rsp1_valid", rsp1_valid, 1'b0);
    end else begin
      chk1("rsp_both", rsp0_valid && rsp1_valid, 1'b0);
      if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          chk1("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk32("rsp_port", rsp1_valid ? 32'd1 : 32'd0, e.port);
          chk32("rsp_result", rsp1_valid ? rsp1_result : rsp0_result, e.res);
          chk32("rsp_cycle", cyc, e.cyc);
          if (e.port == 0) hold0 = e.res; else hold1 = e.res;
        end
      end
    end
    chk32("rsp0_hold", rsp0_result, hold0);
    chk32("rsp1_hold", rsp1_result, hold1);
  end

  task automatic drive(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    int   t;
    logic rdy;
    t = 0;
    rdy = 1'b0;
    if (p == 0) begin
      req0_rd1 = a; req0_rd2 = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_rd1 = a; req1_rd2 = b; req1_op = op; req1_valid = 1'b1;
    end
    while (!rdy && t < 60) begin
      @(negedge clk);
      t++;
      rdy = (p == 0) ? req0_ready : req1_ready;
    end
    chk1(p == 0 ? "drive0_timeout" : "drive1_timeout", rdy, 1'b1);
    @(posedge clk);
    #1;
    if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  initial begin
    int c3, got_rsp;
    logic got_acc;
    // Reset values while n_rst is held low, with requests pending.
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk32("rst_alu_rd1", alu_rd1, 32'h0);
    chk32("rst_alu_rd2", alu_rd2, 32'h0);
    chk32("rst_alu_op", {28'h0, alu_op}, 32'h0);
    chk32("rst_rsp0_result", rsp0_result, 32'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1 n_rst = 1'b1;

    // Conflict right after reset: port 0 first.
    fork
      drive(0, 32'd20, 32'd5, 4'b0110);
      drive(1, 32'hF0, 32'h0F, 4'b0001);
    join
    repeat (LAT + 2) @(negedge clk);
    chk32("conflict_res0", rsp0_result, 32'd15);
    chk32("conflict_res1", rsp1_result, 32'hFF);

    // Basic ADD with exact response timing.
    drive(0, 32'd9, 32'd10, 4'b0010);
    repeat (LAT + 2) @(negedge clk);
    chk1("basic_rsp0_valid", rsp0_valid, 1'b1);
    chk1("basic_rsp1_valid", rsp1_valid, 1'b0);
    chk32("basic_result", rsp0_result, 32'd19);
    @(negedge clk);
    chk1("basic_pulse_end", rsp0_valid, 1'b0);

    // Wrap-around and masking.
    drive(1, 32'h0, 32'h1, 4'b0110);
    repeat (LAT + 2) @(negedge clk);
    chk32("wrap_sub", rsp1_result, 32'hFFFF_FFFF);
    drive(0, 32'hFFFF_0000, 32'h00FF_FF00, 4'b0000);
    repeat (LAT + 2) @(negedge clk);
    chk32("and_mask", rsp0_result, 32'h00FF_0000);

    // Reset in EXEC drops the op; after release a conflict goes to port 0.
    drive(0, 32'd7, 32'd8, 4'b0010);
    @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    chk1("rexec_busy", busy, 1'b0);
    chk32("rexec_alu_rd1", alu_rd1, 32'h0);
    chk32("rexec_alu_rd2", alu_rd2, 32'h0);
    chk32("rexec_alu_op", {28'h0, alu_op}, 32'h0);
    fork
      drive(0, 32'd3, 32'd4, 4'b0010);
      drive(1, 32'd5, 32'd6, 4'b0010);
      begin
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
      end
    join
    repeat (LAT + 3) @(negedge clk);
    chk32("rexec_res0", rsp0_result, 32'd7);
    chk32("rexec_res1", rsp1_result, 32'd11);

    // Fairness: both ports continuously valid for six ops.
    fork
      repeat (3) drive(0, $urandom, $urandom, rand_op());
      repeat (3) drive(1, $urandom, $urandom, rand_op());
    join
    repeat (LAT + 3) @(negedge clk);
`ifdef ALU_ARB_STATS_EN
    chk32("grant_cnt0", {16'h0, gc0}, m_g0);
    chk32("grant_cnt1", {16'h0, gc1}, m_g1);
    chk32("conflict_cnt", {16'h0, cc}, m_conf);
`endif

    // Randomized traffic with random idle gaps.
    fork
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 drive(0, $urandom, $urandom, rand_op());
      end
      for (int j = 0; j < 12; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 drive(1, $urandom, $urandom, rand_op());
      end
    join
    repeat (LAT + 4) @(negedge clk);

    // ALU_LAT=3 instance: latency and spacing of back-to-back accepts.
    r3_rd1 = 32'd1; r3_rd2 = 32'd2; r3_op = 4'b0010; r3_valid = 1'b1;
    c3 = -1;
    for (int t = 0; t < 20 && c3 < 0; t++) begin
      @(negedge clk);
      if (r3_ready) c3 = cyc;
    end
    chk1("lat3_first_accept", c3 >= 0, 1'b1);
    @(posedge clk);
    #1;
    r3_rd1 = 32'd5; r3_rd2 = 32'd6;
    got_rsp = 0;
    got_acc = 1'b0;
    for (int t = 0; t < 30 && got_rsp < 2; t++) begin
      @(negedge clk);
      if (r3_rsp_valid) begin
        if (got_rsp == 0) begin
          chk32("lat3_rsp_cycle", cyc, c3 + LAT3 + 2);
          chk32("lat3_result", r3_rsp_result, 32'd3);
        end else begin
          chk32("lat3_result2", r3_rsp_result, 32'd11);
        end
        got_rsp++;
      end
      if (r3_ready && !got_acc) begin
        chk32("lat3_next_accept", cyc, c3 + LAT3 + 3);
        got_acc = 1'b1;
        @(posedge clk);
        #1 r3_valid = 1'b0;
      end
    end
    r3_valid = 1'b0;
    chk32("lat3_rsp_count", got_rsp, 32'd2);

    repeat (4) @(negedge clk);
    chk32("scoreboard_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
